// File: rtl/nvme_regs_pkg.sv
// Shared constants and types for the NVMe controller register file.
package nvme_regs_pkg;

  localparam logic [15:0] OffCapLo = 16'h0000;
  localparam logic [15:0] OffCapHi = 16'h0004;
  localparam logic [15:0] OffVs    = 16'h0008;
  localparam logic [15:0] OffCc    = 16'h0014;
  localparam logic [15:0] OffCsts  = 16'h001C;
  localparam logic [15:0] OffAqa   = 16'h0024;
  localparam logic [15:0] OffAsqLo = 16'h0028;
  localparam logic [15:0] OffAsqHi = 16'h002C;
  localparam logic [15:0] OffAcqLo = 16'h0030;
  localparam logic [15:0] OffAcqHi = 16'h0034;

  localparam logic [15:0] DbBase = 16'h1000;

  localparam logic [31:0] VsValue   = 32'h0001_0400;
  localparam logic [31:0] CcWrMask  = 32'h00FF_C001;
  localparam logic [31:0] AqaWrMask = 32'h0FFF_0FFF;
  localparam logic [31:0] BaseMask  = 32'hFFFF_F000;

  localparam logic [1:0] ShstNormal = 2'b00;
  localparam logic [1:0] ShstOccur  = 2'b01;
  localparam logic [1:0] ShstCmplt  = 2'b10;

  typedef enum logic [1:0] {
    StDisabled,
    StEnabling,
    StReady,
    StResetting
  } state_e;

endpackage

// File: rtl/nvme_ctrl_regs_if.sv
// Host BAR0 register access port: single-cycle write strobe, registered read.
interface nvme_ctrl_regs_if;
  logic [15:0] addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output addr, wr_data, wr_en, rd_en, input rd_data, rd_valid);
  modport slave  (input addr, wr_data, wr_en, rd_en, output rd_data, rd_valid);
endinterface

// File: rtl/nvme_db_decode.sv
// Combinational doorbell address decode: byte address to queue id and SQ/CQ select.
module nvme_db_decode import nvme_regs_pkg::*; #(
  parameter int unsigned NUM_IO_QUEUES = 4,
  parameter int unsigned DSTRD         = 0
) (
  input  logic [15:0] addr_i,
  output logic        hit_o,
  output logic [7:0]  qid_o,
  output logic        is_cq_o
);

  localparam int unsigned NumQ       = NUM_IO_QUEUES + 1;
  localparam int unsigned Shift      = DSTRD + 2;
  localparam logic [15:0] StrideMask = 16'((32'd4 << DSTRD) - 32'd1);

  logic [15:0] off;
  logic [15:0] idx;
  logic [14:0] y;

  always_comb begin
    off     = {addr_i[15:2], 2'b00} - DbBase;
    idx     = off >> Shift;
    y       = idx[15:1];
    is_cq_o = idx[0];
    qid_o   = y[7:0];
    hit_o   = (addr_i >= DbBase) && ((off & StrideMask) == 16'd0) && ({17'd0, y} < NumQ);
  end

endmodule

// File: rtl/nvme_ctrl_regs.sv
// NVMe controller register file: CAP/VS/CC/CSTS/AQA/ASQ/ACQ, enable and shutdown
// sequencing, and doorbell pulse generation toward the queue engines.
module nvme_ctrl_regs import nvme_regs_pkg::*; #(
  parameter int unsigned NUM_IO_QUEUES = 4,
  parameter int unsigned DSTRD         = 0,
  parameter int unsigned MQES          = 63,
  parameter int unsigned TO            = 1,
  parameter int unsigned RDY_DELAY     = 8,
  parameter int unsigned SHN_DELAY     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nvme_ctrl_regs_if.slave       bus,
  output logic                  cc_en,
  output logic                  csts_rdy,
  output logic [63:0]           asq_base,
  output logic [63:0]           acq_base,
  output logic [11:0]           asqs,
  output logic [11:0]           acqs,
  output logic                  db_valid,
  output logic [7:0]            db_qid,
  output logic                  db_is_cq,
  output logic [15:0]           db_value
);

  localparam logic [15:0] Mqes    = 16'(MQES);
  localparam logic [31:0] CapLo   = {8'(TO), 7'd0, 1'b1, Mqes};
  localparam logic [31:0] CapHi   = 32'h0000_0020 | {28'd0, 4'(DSTRD)};
  localparam logic [31:0] RdyLoad = 32'(RDY_DELAY) - 32'd1;
  localparam logic [31:0] ShnLoad = 32'(SHN_DELAY) - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] shn_cnt_q, shn_cnt_d;
  logic [31:0] cc_q, cc_d;
  logic [31:0] aqa_q, aqa_d;
  logic [63:0] asq_q, asq_d;
  logic [63:0] acq_q, acq_d;
  logic        cfs_q, cfs_d;
  logic [1:0]  shst_q, shst_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        db_valid_q, db_valid_d;
  logic [7:0]  db_qid_q, db_qid_d;
  logic        db_is_cq_q, db_is_cq_d;
  logic [15:0] db_value_q, db_value_d;

  logic [15:0] waddr;
  logic        cc_wr;
  logic        db_hit;
  logic [7:0]  db_qid_w;
  logic        db_is_cq_w;
  logic [15:0] db_bound;
  logic        rdy;
  logic [31:0] rd_val;

  nvme_db_decode #(
    .NUM_IO_QUEUES(NUM_IO_QUEUES),
    .DSTRD        (DSTRD)
  ) u_db_decode (
    .addr_i (bus.addr),
    .hit_o  (db_hit),
    .qid_o  (db_qid_w),
    .is_cq_o(db_is_cq_w)
  );

  assign waddr = {bus.addr[15:2], 2'b00};
  assign cc_wr = bus.wr_en && (waddr == OffCc);
  assign rdy   = (state_q == StReady);

  // Admin queue sizes come from AQA; IO queues share the MQES limit.
  assign db_bound = (db_qid_w == 8'd0) ? (db_is_cq_w ? {4'd0, aqa_q[27:16]} : {4'd0, aqa_q[11:0]})
                                       : Mqes;

  always_comb begin
    rd_val = 32'd0;
    case (waddr)
      OffCapLo: rd_val = CapLo;
      OffCapHi: rd_val = CapHi;
      OffVs:    rd_val = VsValue;
      OffCc:    rd_val = cc_q;
      OffCsts:  rd_val = {28'd0, shst_q, cfs_q, rdy};
      OffAqa:   rd_val = aqa_q;
      OffAsqLo: rd_val = asq_q[31:0];
      OffAsqHi: rd_val = asq_q[63:32];
      OffAcqLo: rd_val = acq_q[31:0];
      OffAcqHi: rd_val = acq_q[63:32];
      default:  rd_val = 32'd0;
    endcase
  end

  always_comb begin
    rd_data_d  = bus.rd_en ? rd_val : 32'd0;
    rd_valid_d = bus.rd_en;

    cc_d = cc_q;
    if (cc_wr) cc_d = bus.wr_data & CcWrMask;

    aqa_d = aqa_q;
    asq_d = asq_q;
    acq_d = acq_q;
    if (bus.wr_en && (state_q == StDisabled)) begin
      case (waddr)
        OffAqa:   aqa_d         = bus.wr_data & AqaWrMask;
        OffAsqLo: asq_d[31:0]   = bus.wr_data & BaseMask;
        OffAsqHi: asq_d[63:32]  = bus.wr_data;
        OffAcqLo: acq_d[31:0]   = bus.wr_data & BaseMask;
        OffAcqHi: acq_d[63:32]  = bus.wr_data;
        default:  ;
      endcase
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    shn_cnt_d  = shn_cnt_q;
    cfs_d      = cfs_q;
    shst_d     = shst_q;
    db_valid_d = 1'b0;
    db_qid_d   = db_qid_q;
    db_is_cq_d = db_is_cq_q;
    db_value_d = db_value_q;

    unique case (state_q)
      StDisabled: begin
        if (cc_d[0]) begin
          state_d = StEnabling;
          cnt_d   = RdyLoad;
        end
      end
      StEnabling: begin
        if (!cc_d[0]) begin
          state_d = StResetting;
          cnt_d   = RdyLoad;
        end else if (cnt_q == 32'd0) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StReady: begin
        if (!cc_d[0]) begin
          state_d = StResetting;
          cnt_d   = RdyLoad;
        end else if (cc_wr && (bus.wr_data[15:14] != 2'b00) && (shst_q == ShstNormal)) begin
          shst_d    = ShstOccur;
          shn_cnt_d = ShnLoad;
        end else if (shst_q == ShstOccur) begin
          if (shn_cnt_q == 32'd0) shst_d = ShstCmplt;
          else                    shn_cnt_d = shn_cnt_q - 32'd1;
        end
        if (bus.wr_en && db_hit) begin
          if (bus.wr_data[15:0] > db_bound) begin
            cfs_d = 1'b1;
          end else begin
            db_valid_d = 1'b1;
            db_qid_d   = db_qid_w;
            db_is_cq_d = db_is_cq_w;
            db_value_d = bus.wr_data[15:0];
          end
        end
      end
      StResetting: begin
        if (cnt_q == 32'd0) begin
          state_d = StDisabled;
          cfs_d   = 1'b0;
          shst_d  = ShstNormal;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = StDisabled;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StDisabled;
      cnt_q      <= 32'd0;
      shn_cnt_q  <= 32'd0;
      cc_q       <= 32'd0;
      aqa_q      <= 32'd0;
      asq_q      <= 64'd0;
      acq_q      <= 64'd0;
      cfs_q      <= 1'b0;
      shst_q     <= ShstNormal;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      db_valid_q <= 1'b0;
      db_qid_q   <= 8'd0;
      db_is_cq_q <= 1'b0;
      db_value_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shn_cnt_q  <= shn_cnt_d;
      cc_q       <= cc_d;
      aqa_q      <= aqa_d;
      asq_q      <= asq_d;
      acq_q      <= acq_d;
      cfs_q      <= cfs_d;
      shst_q     <= shst_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      db_valid_q <= db_valid_d;
      db_qid_q   <= db_qid_d;
      db_is_cq_q <= db_is_cq_d;
      db_value_q <= db_value_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign cc_en        = cc_q[0];
  assign csts_rdy     = rdy;
  assign asq_base     = asq_q;
  assign acq_base     = acq_q;
  assign asqs         = aqa_q[11:0];
  assign acqs         = aqa_q[27:16];
  assign db_valid     = db_valid_q;
  assign db_qid       = db_qid_q;
  assign db_is_cq     = db_is_cq_q;
  assign db_value     = db_value_q;

endmodule

// File: tb/tb_nvme_ctrl_regs.sv
// Directed bench for nvme_ctrl_regs: default build plus a 2-queue, stride-8 build.
module tb_nvme_ctrl_regs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nvme_ctrl_regs_if bus ();
  nvme_ctrl_regs_if bus2 ();

  logic        cc_en, csts_rdy, db_valid, db_is_cq;
  logic [63:0] asq_base, acq_base;
  logic [11:0] asqs, acqs;
  logic [7:0]  db_qid;
  logic [15:0] db_value;

  logic        cc_en2, csts_rdy2, db_valid2, db_is_cq2;
  logic [63:0] asq_base2, acq_base2;
  logic [11:0] asqs2, acqs2;
  logic [7:0]  db_qid2;
  logic [15:0] db_value2;

  nvme_ctrl_regs u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .cc_en   (cc_en),
    .csts_rdy(csts_rdy),
    .asq_base(asq_base),
    .acq_base(acq_base),
    .asqs    (asqs),
    .acqs    (acqs),
    .db_valid(db_valid),
    .db_qid  (db_qid),
    .db_is_cq(db_is_cq),
    .db_value(db_value)
  );

  nvme_ctrl_regs #(
    .NUM_IO_QUEUES(2),
    .DSTRD        (1)
  ) u_dut2 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus2),
    .cc_en   (cc_en2),
    .csts_rdy(csts_rdy2),
    .asq_base(asq_base2),
    .acq_base(acq_base2),
    .asqs    (asqs2),
    .acqs    (acqs2),
    .db_valid(db_valid2),
    .db_qid  (db_qid2),
    .db_is_cq(db_is_cq2),
    .db_value(db_value2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks are entered at a negedge and return at the following negedge.
  task automatic wr(input bit d2, input logic [15:0] a, input logic [31:0] d);
    if (d2) begin
      bus2.addr = a; bus2.wr_data = d; bus2.wr_en = 1'b1;
    end else begin
      bus.addr = a; bus.wr_data = d; bus.wr_en = 1'b1;
    end
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus2.wr_en = 1'b0;
  endtask

  task automatic rd(input bit d2, input logic [15:0] a, output logic [31:0] v);
    if (d2) begin
      bus2.addr = a; bus2.rd_en = 1'b1;
    end else begin
      bus.addr = a; bus.rd_en = 1'b1;
    end
    @(negedge clk);
    bus.rd_en  = 1'b0;
    bus2.rd_en = 1'b0;
    chk("rd_valid", {63'd0, d2 ? bus2.rd_valid : bus.rd_valid}, 64'd1);
    v = d2 ? bus2.rd_data : bus.rd_data;
  endtask

  task automatic rw(input logic [15:0] a, input logic [31:0] d, output logic [31:0] v);
    bus.addr = a; bus.wr_data = d; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    v = bus.rd_data;
  endtask

  logic [31:0] v;
  logic        seen;

  initial begin
    bus.addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus2.addr = '0; bus2.wr_data = '0; bus2.wr_en = 1'b0; bus2.rd_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_cc_en", {63'd0, cc_en}, 64'd0);
    chk("rst_rdy", {63'd0, csts_rdy}, 64'd0);
    chk("rst_asq", asq_base, 64'd0);
    chk("rst_acq", acq_base, 64'd0);
    chk("rst_aqa", {40'd0, acqs, asqs}, 64'd0);
    chk("rst_db", {38'd0, db_valid, db_is_cq, db_qid, db_value}, 64'd0);
    chk("rst_rd_valid", {63'd0, bus.rd_valid}, 64'd0);

    rd(0, 16'h0000, v); chk("cap_lo", v, 64'h0101_003F);
    rd(0, 16'h0004, v); chk("cap_hi", v, 64'h0000_0020);
    rd(0, 16'h0008, v); chk("vs", v, 64'h0001_0400);
    @(negedge clk);
    chk("rd_valid_drop", {63'd0, bus.rd_valid}, 64'd0);
    rd(0, 16'h001C, v); chk("csts_rst", v, 64'd0);
    rd(0, 16'h0040, v); chk("unmapped_rd", v, 64'd0);

    wr(0, 16'h0024, 32'h0001_0002);
    rw(16'h0024, 32'h000F_000F, v); chk("rw_old", v, 64'h0001_0002);
    rd(0, 16'h0024, v); chk("aqa_rb", v, 64'h000F_000F);
    wr(0, 16'h0028, 32'h0000_1000);
    wr(0, 16'h002C, 32'h0000_0000);
    wr(0, 16'h0030, 32'h0000_2ABC);
    chk("asqs", {52'd0, asqs}, 64'h00F);
    chk("acqs", {52'd0, acqs}, 64'h00F);
    chk("asq_base", asq_base, 64'h1000);
    chk("acq_mask", acq_base, 64'h2000);

    // Enable: RDY rises on the 8th edge after the accepting edge.
    wr(0, 16'h0014, 32'h0046_0001);
    chk("rdy_e0", {63'd0, csts_rdy}, 64'd0);
    chk("cc_en", {63'd0, cc_en}, 64'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("rdy_wait", {63'd0, csts_rdy}, 64'd0);
    end
    @(negedge clk);
    chk("rdy_up", {63'd0, csts_rdy}, 64'd1);

    wr(0, 16'h1008, 32'd5);
    chk("db_pulse", {38'd0, db_valid, db_is_cq, db_qid, db_value}, {38'd0, 1'b1, 1'b0, 8'd1, 16'd5});
    @(negedge clk);
    chk("db_one_cycle", {63'd0, db_valid}, 64'd0);
    wr(0, 16'h1008, 32'h40);
    chk("db_over_mqes", {63'd0, db_valid}, 64'd0);
    rd(0, 16'h001C, v); chk("csts_cfs", v, 64'h3);
    wr(0, 16'h1000, 32'h10);
    chk("db_over_asqs", {63'd0, db_valid}, 64'd0);
    wr(0, 16'h1004, 32'h0F);
    chk("db_admin_cq", {38'd0, db_valid, db_is_cq, db_qid, db_value}, {38'd0, 1'b1, 1'b1, 8'd0, 16'h0F});
    wr(0, 16'h1028, 32'd1);
    chk("db_q_range", {63'd0, db_valid}, 64'd0);
    rd(0, 16'h1008, v); chk("db_rd_zero", v, 64'd0);

    wr(0, 16'h0028, 32'h0000_5000);
    rd(0, 16'h0028, v); chk("asq_locked", v, 64'h1000);
    chk("asq_base_locked", asq_base, 64'h1000);

    // Shutdown: SHST=01 next cycle, 10 after 16 cycles.
    wr(0, 16'h0014, 32'h0046_4001);
    rd(0, 16'h001C, v); chk("shst_occur", v, 64'h7);
    repeat (14) @(negedge clk);
    rd(0, 16'h001C, v); chk("shst_e15", v, 64'h7);
    rd(0, 16'h001C, v); chk("shst_cmplt", v, 64'hB);
    chk("rdy_in_shn", {63'd0, csts_rdy}, 64'd1);

    wr(0, 16'h0014, 32'h0046_0F00);
    chk("rdy_drop", {63'd0, csts_rdy}, 64'd0);
    chk("cc_en_off", {63'd0, cc_en}, 64'd0);
    repeat (7) @(negedge clk);
    rd(0, 16'h001C, v); chk("resetting", v, 64'hA);
    rd(0, 16'h001C, v); chk("disabled_clr", v, 64'h0);
    rd(0, 16'h0014, v); chk("cc_mask", v, 64'h0046_0000);

    // Abort during enable.
    wr(0, 16'h0014, 32'h0000_0001);
    repeat (2) @(negedge clk);
    wr(0, 16'h0014, 32'h0000_0000);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (csts_rdy) seen = 1'b1;
    end
    chk("abort_no_rdy", {63'd0, seen}, 64'd0);
    wr(0, 16'h0028, 32'h0000_7000);
    chk("abort_disabled", asq_base, 64'h7000);

    // EN=1 written during RESETTING waits for DISABLED.
    wr(0, 16'h0014, 32'h0000_0001);
    repeat (8) @(negedge clk);
    chk("rdy_again", {63'd0, csts_rdy}, 64'd1);
    wr(0, 16'h0014, 32'h0000_0000);
    @(negedge clk);
    wr(0, 16'h0014, 32'h0000_0001);
    repeat (14) @(negedge clk);
    chk("reen_wait", {63'd0, csts_rdy}, 64'd0);
    @(negedge clk);
    chk("reen_rdy", {63'd0, csts_rdy}, 64'd1);

    // Second build: 2 IO queues, 8-byte stride.
    rd(1, 16'h0004, v); chk("cap_hi2", v, 64'h21);
    wr(1, 16'h0014, 32'h0000_0001);
    repeat (8) @(negedge clk);
    chk("rdy2", {63'd0, csts_rdy2}, 64'd1);
    wr(1, 16'h1028, 32'd3);
    chk("db2_q2cq", {38'd0, db_valid2, db_is_cq2, db_qid2, db_value2},
        {38'd0, 1'b1, 1'b1, 8'd2, 16'd3});
    wr(1, 16'h1030, 32'd4);
    chk("db2_range", {63'd0, db_valid2}, 64'd0);
    wr(1, 16'h1004, 32'd4);
    chk("db2_align", {63'd0, db_valid2}, 64'd0);
    rd(1, 16'h001C, v); chk("csts2", v, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvme_ctrl_regs.md
Name: nvme_ctrl_regs

Overview:
- Parametrised NVMe controller register file. Successor to the fixed CAP-only register block.
- Holds CAP/VS/CC/CSTS/AQA/ASQ/ACQ and a doorbell array sized by queue count and stride.
- Runs the CC.EN→CSTS.RDY enable/disable sequence and the CC.SHN→CSTS.SHST shutdown sequence.
- Sits between the host BAR0 slave port and the queue/command engines, which consume doorbell pulses and admin queue bases.

Parameters:
- NUM_IO_QUEUES, 4: IO queue pairs; total queues Q = NUM_IO_QUEUES+1 (qid 0 = admin).
- DSTRD, 0: doorbell stride exponent; stride = 4<<DSTRD bytes.
- MQES, 63: max IO queue entries, 0's based, 16 bits.
- TO, 1: CAP.TO timeout field, 8 bits.
- RDY_DELAY, 8: cycles from enable accept to CSTS.RDY=1; also reset-sweep length on disable.
- SHN_DELAY, 16: cycles from shutdown request to SHST=complete.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr  in  16  byte address; bits [1:0] ignored
- wr_data  in  32  write data
- wr_en  in  1  write strobe, one cycle per access
- rd_en  in  1  read strobe
- rd_data  out  32  read data, registered
- rd_valid  out  1  high the cycle after rd_en
- cc_en  out  1  CC.EN
- csts_rdy  out  1  CSTS.RDY
- asq_base  out  64  ASQ, bits [11:0] forced 0
- acq_base  out  64  ACQ, bits [11:0] forced 0
- asqs  out  12  AQA.ASQS
- acqs  out  12  AQA.ACQS
- db_valid  out  1  one-cycle doorbell pulse
- db_qid  out  8  queue id of the pulse
- db_is_cq  out  1  0 = SQ tail, 1 = CQ head
- db_value  out  16  written doorbell value

Behaviour:
- Reset: all registers 0, state DISABLED, all outputs 0.
- CAP_LO(0x00) = {TO, 7'b0, CQR=1, MQES}; default value 0x0101_003F.
- CAP_HI(0x04) = 0x0000_0020 | DSTRD (CSS.NVM=1, NSSRS=0, MPSMIN=MPSMAX=0).
- VS(0x08) = 0x0001_0400.
- CC(0x14): bits EN[0], SHN[15:14], IOSQES[19:16], IOCQES[23:20] writable; other bits read 0.
- CSTS(0x1C), read-only: RDY[0], CFS[1], SHST[3:2].
- AQA(0x24), ASQ(0x28/0x2C), ACQ(0x30/0x34): writable only in DISABLED; writes in any other state are dropped.
- Unmapped reads return 0. Unmapped writes are ignored.
- Reads: rd_data and rd_valid appear exactly 1 cycle after rd_en. A read and write to the same address in one cycle returns the old value.
- State machine, DISABLED → ENABLING: when CC.EN=1. Counter loads RDY_DELAY.
- ENABLING → READY: counter hits 0. RDY=1.
- ENABLING → RESETTING: EN written 0 mid-count; abort immediately.
- READY → RESETTING: EN written 0. RDY drops the next cycle.
- RESETTING → DISABLED: after RDY_DELAY cycles. CFS and SHST cleared on entry to DISABLED.
- EN written 1 during RESETTING: stored, but not acted on until DISABLED is reached. DISABLED then moves to ENABLING on the following cycle.
- Shutdown: SHN written nonzero while READY → SHST=01 the next cycle. After SHN_DELAY cycles SHST=10. RDY stays 1.
- SHN writes outside READY are stored but do not change SHST.
- Doorbells start at 0x1000. Queue y SQ tail is at 0x1000 + (2y)*stride; CQ head is at 0x1000 + (2y+1)*stride.
- Doorbell offsets that are not stride-aligned, or that map to y ≥ Q, are unmapped.
- A doorbell write in READY produces db_valid the next cycle, with db_value = wr_data[15:0].
- Doorbell writes outside READY are dropped with no pulse.
- Admin SQ/CQ bound is ASQS/ACQS; IO bound is MQES.
- Doorbell value > bound: no db_valid pulse; CSTS.CFS set, sticky until DISABLED.
- Doorbell reads return 0.

Decomposition:
- Package nvme_regs_pkg holds:
  - register offset constants
  - VS value
  - CSTS.SHST encodings
  - state enum (DISABLED, ENABLING, READY, RESETTING)
  - doorbell base constant
- One sub-module, nvme_db_decode: combinational address → {hit, qid, is_cq}, parametrised by NUM_IO_QUEUES and DSTRD.

Test Plan:
- After reset, read 0x00/0x04/0x08 → 0x0101_003F / 0x0000_0020 / 0x0001_0400, each with rd_valid 1 cycle after rd_en.
- Write AQA=0x000F_000F, ASQ=0x1000, ACQ=0x2000, then CC=0x0046_0001 → CSTS.RDY=1 exactly 8 cycles after EN accepted; asq_base=0x1000.
- In READY, write 5 to 0x1008 (q1 SQ, DSTRD=0) → db_valid with qid=1, is_cq=0, value=5. Write 0x40 to 0x1008 → no pulse, CSTS.CFS=1.
- In READY, write CC.SHN=01 → SHST=01 next cycle, SHST=10 after 16 cycles. Then write EN=0 → RDY=0 next cycle; DISABLED after 8 cycles with CFS=0 and SHST=00.
- Write EN=0 at ENABLING cycle 3 → RDY never asserts. A write to ASQ during READY → readback unchanged.
- Rebuild with NUM_IO_QUEUES=2, DSTRD=1: write 0x1028 (q2 CQ) → qid=2, is_cq=1. Write 0x1030 or 0x1004 → ignored.
